alien_fleet: RTL and testbench
==============================

Name: alien_fleet

Overview:
Owns the invader formation: a ROWS x COLS bitmap of live aliens that marches horizontally on a fixed step timer and drops one row at each screen edge. Sits directly downstream of the player block. Consumes the player's bullet position, detects bullet/alien collisions, and returns the one-cycle hit pulse that retires the bullet. Also produces fleet position, alive bitmap, score and game status for the renderer and top level.

Parameters:
ROWS, 4, alien rows (1..8)
COLS, 8, alien columns; aliens occupy every second x cell, so fleet width = 2*COLS-1 cells (must be <= 32)
STEP_CYCLES, 9000000, clock cycles between fleet moves (0.25 s at 36 MHz)
START_X, 0, fleet x (column 0 alien) after reset or reload
START_Y, 1, fleet y (row 0) after reset or reload
LOSE_ROW, 14, y at which a live alien ends the game

Ports:
i_clk_36MHz  in  1  system clock
i_reset  in  1  asynchronous, active-high reset
i_bullet_x  in  5  player bullet column
i_bullet_y  in  4  player bullet row; 4'd15 = no bullet in flight
o_hit  out  1  one-cycle pulse, bullet destroyed an alien (drives player i_hit)
o_fleet_x  out  5  x of column-0 alien
o_fleet_y  out  4  y of row-0 alien
o_alive  out  ROWS*COLS  bit r*COLS+c = alien (r,c) alive
o_score  out  8  aliens destroyed, saturates at 255
o_game_over  out  1  level, fleet reached LOSE_ROW
o_wave_clear  out  1  one-cycle pulse when last alien destroyed

Behaviour:
- Reset (async, any state): fleet_x=START_X, fleet_y=START_Y, direction=right, o_alive=all ones, step counter=0, o_score=0, o_hit=0, o_wave_clear=0, o_game_over=0, state=PLAY.
- Alien (r,c) occupies x=fleet_x+2c, y=fleet_y+r.
- States: PLAY, RELOAD, OVER.
- PLAY, collision (checked every cycle, registered outputs, 1-cycle latency):
  - Condition: i_bullet_y!=15, dy=i_bullet_y-fleet_y in 0..ROWS-1, dx=i_bullet_x-fleet_x in 0..2*COLS-2, dx even, and alien (dy,dx/2) alive.
  - Response on next edge: clear that bit, o_hit=1 for exactly one cycle, score+1 (saturating).
  - At most one alien cleared per cycle. Bullet held still after a hit cannot re-hit: the bit is already cleared.
- PLAY, step counter: counts 0..STEP_CYCLES-1. At terminal count it wraps to 0 and the fleet moves:
  - direction right and fleet_x+2*COLS-2==31 -> fleet_y+1, direction=left, x unchanged.
  - direction left and fleet_x==0 -> fleet_y+1, direction=right, x unchanged.
  - otherwise fleet_x +/-1.
- Same-cycle collision and step: collision is evaluated against the pre-step position; the bitmap clear and the move both commit on the same edge.
- Lowest live row L = highest r with any alive bit. If fleet_y+L >= LOSE_ROW (evaluated on post-update values) -> OVER next cycle.
- Bitmap becomes all zero -> o_wave_clear pulses one cycle, state=RELOAD.
- RELOAD: one cycle. Restores bitmap to all ones, position to START_X/START_Y, direction=right, counter=0; returns to PLAY. Score is kept. No hit detection during RELOAD.
- OVER: all state frozen, o_game_over=1, o_hit=0. Only reset exits.
- Last alien hit on the same cycle it reaches LOSE_ROW: wave clear wins; no game over.
- fleet_y arithmetic uses 5 bits internally so it cannot wrap past 15.

Decomposition:
- Shared package space_invaders_pkg: screen constants SCREEN_W=32, SCREEN_H=16, BULLET_IDLE_Y=4'd15, and the state enum {PLAY, RELOAD, OVER}. The player/bullet side also uses BULLET_IDLE_Y.
- One natural sub-module, fleet_collision: purely combinational. Inputs are bullet x/y, fleet x/y and alive bitmap; outputs are hit_valid and hit_index. It keeps the decode separately testable.
- Timer, mover, FSM and score stay in alien_fleet.

Test Plan:
- Reset then idle, STEP_CYCLES=4, i_bullet_y=15 -> o_fleet_x goes 0,1,2... every 4 cycles; at x=17 the next step gives x=17, y=2, then x decrements.
- Bullet at (4,2) with fleet at (0,1) -> o_hit pulses once one cycle later; bit 1*8+2=10 clears; o_score=1. Holding the bullet there produces no further hits.
- Bullet at odd dx (3,1) or at x=16 -> no hit; bitmap unchanged.
- Hit forced on the step terminal cycle -> the alien at the pre-step position clears and the fleet still moves by 1.
- Clear all 32 aliens -> o_wave_clear pulses once, next cycle o_alive is all ones at (0,1), o_score=32.
- Let the fleet descend with the bottom row alive until y+3=14 -> o_game_over=1 and outputs frozen. Repeat with row 3 cleared -> game over is delayed one extra descent. Asserting reset mid-game returns all outputs to reset values immediately.

Source files
------------

// File: rtl/space_invaders_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : space_invaders_pkg
//  Brief    : Screen constants, bullet idle marker and fleet state encoding
//             shared by the player and alien fleet blocks.
//  Revision : 1.0  initial release
// ============================================================================
package space_invaders_pkg;

    localparam int SCREEN_W = 32;
    localparam int SCREEN_H = 16;

    // Bullet row value meaning "no bullet in flight".
    localparam logic [3:0] BULLET_IDLE_Y = 4'd15;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        RELOAD = 2'd1,
        OVER   = 2'd2
    } fleet_state_e;

    // Score counter increment that sticks at the top value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fleet_collision.sv
`default_nettype none
// ============================================================================
//  Module   : fleet_collision
//  Brief    : Combinational bullet/alien decode. Maps the bullet position
//             into the fleet grid and reports whether it lands on a live
//             alien, plus that alien's bitmap index.
//  Revision : 1.0  initial release
// ============================================================================
module fleet_collision
    import space_invaders_pkg::*;
#(
    parameter int ROWS  = 4,
    parameter int COLS  = 8,
    parameter int IDX_W = 5
) (
    input  logic [4:0]           bullet_x_i,
    input  logic [3:0]           bullet_y_i,
    input  logic [4:0]           fleet_x_i,
    input  logic [4:0]           fleet_y_i,
    input  logic [ROWS*COLS-1:0] alive_i,
    output logic                 hit_valid_o,
    output logic [IDX_W-1:0]     hit_index_o
);

    localparam logic [4:0] c_ROWS   = 5'(ROWS);
    localparam logic [4:0] c_DX_MAX = 5'(2*COLS-2);

    logic [4:0] w_dx;
    logic [4:0] w_dy;
    logic       w_in_grid;
    logic [9:0] w_idx_wide;

    // Offsets are only meaningful once the bullet is known to be at or
    // beyond the fleet origin; w_in_grid guards the wrapped cases.
    assign w_dx = bullet_x_i - fleet_x_i;
    assign w_dy = {1'b0, bullet_y_i} - fleet_y_i;

    assign w_in_grid = (bullet_y_i != BULLET_IDLE_Y)
                     && (bullet_x_i >= fleet_x_i)
                     && ({1'b0, bullet_y_i} >= fleet_y_i)
                     && (w_dy < c_ROWS)
                     && (w_dx <= c_DX_MAX)
                     && !w_dx[0];

    // Aliens sit on even columns only, so dx/2 is the alien column.
    assign w_idx_wide  = 10'(w_dy) * 10'(COLS) + 10'(w_dx[4:1]);
    assign hit_index_o = w_idx_wide[IDX_W-1:0];
    assign hit_valid_o = w_in_grid && alive_i[hit_index_o];

endmodule
`default_nettype wire

// File: rtl/alien_fleet.sv
`default_nettype none
// ============================================================================
//  Module   : alien_fleet
//  Brief    : Invader formation: live-alien bitmap, step timer, horizontal
//             march with edge drop, bullet hit response, score, wave reload
//             and game-over detection.
//  Revision : 1.0  initial release
// ============================================================================
module alien_fleet
    import space_invaders_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLS        = 8,
    parameter int STEP_CYCLES = 9000000,
    parameter int START_X     = 0,
    parameter int START_Y     = 1,
    parameter int LOSE_ROW    = 14
) (
    input  logic                 i_clk_36MHz,
    input  logic                 i_reset,
    input  logic [4:0]           i_bullet_x,
    input  logic [3:0]           i_bullet_y,
    output logic                 o_hit,
    output logic [4:0]           o_fleet_x,
    output logic [3:0]           o_fleet_y,
    output logic [ROWS*COLS-1:0] o_alive,
    output logic [7:0]           o_score,
    output logic                 o_game_over,
    output logic                 o_wave_clear
);

    localparam int N     = ROWS * COLS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

    localparam logic [CNT_W-1:0] c_STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [4:0]       c_START_X    = 5'(START_X);
    localparam logic [4:0]       c_START_Y    = 5'(START_Y);
    localparam logic [5:0]       c_RIGHT_SPAN = 6'(2*COLS - 2);
    localparam logic [5:0]       c_X_MAX      = 6'(SCREEN_W - 1);
    localparam logic [5:0]       c_LOSE_ROW   = 6'(LOSE_ROW);
    localparam logic [N-1:0]     c_ALL_ALIVE  = {N{1'b1}};

    fleet_state_e     state_q, state_d;
    logic [4:0]       fleet_x_q, fleet_x_d;
    logic [4:0]       fleet_y_q, fleet_y_d;   // 5 bits: drops never wrap
    logic             dir_right_q, dir_right_d;
    logic [N-1:0]     alive_q, alive_d;
    logic [7:0]       score_q, score_d;
    logic             hit_q, hit_d;
    logic             wave_q, wave_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             w_hit_valid;
    logic [IDX_W-1:0] w_hit_index;
    logic             w_empty;
    logic             w_lose;
    logic [2:0]       w_bottom_row;
    logic [5:0]       w_bottom_y;

    fleet_collision #(
        .ROWS  (ROWS),
        .COLS  (COLS),
        .IDX_W (IDX_W)
    ) u_collision (
        .bullet_x_i  (i_bullet_x),
        .bullet_y_i  (i_bullet_y),
        .fleet_x_i   (fleet_x_q),
        .fleet_y_i   (fleet_y_q),
        .alive_i     (alive_q),
        .hit_valid_o (w_hit_valid),
        .hit_index_o (w_hit_index)
    );

    // State register.
    always_ff @(posedge i_clk_36MHz or posedge i_reset) begin
        if (i_reset) state_q <= PLAY;
        else         state_q <= state_d;
    end

    // Datapath registers: position, direction, bitmap, score, timer, pulses.
    always_ff @(posedge i_clk_36MHz or posedge i_reset) begin
        if (i_reset) begin
            fleet_x_q   <= c_START_X;
            fleet_y_q   <= c_START_Y;
            dir_right_q <= 1'b1;
            alive_q     <= c_ALL_ALIVE;
            score_q     <= 8'd0;
            hit_q       <= 1'b0;
            wave_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            fleet_x_q   <= fleet_x_d;
            fleet_y_q   <= fleet_y_d;
            dir_right_q <= dir_right_d;
            alive_q     <= alive_d;
            score_q     <= score_d;
            hit_q       <= hit_d;
            wave_q      <= wave_d;
            cnt_q       <= cnt_d;
        end
    end

    // Datapath next-state: hit against pre-step position, then the march.
    always_comb begin
        fleet_x_d    = fleet_x_q;
        fleet_y_d    = fleet_y_q;
        dir_right_d  = dir_right_q;
        alive_d      = alive_q;
        score_d      = score_q;
        hit_d        = 1'b0;
        wave_d       = 1'b0;
        cnt_d        = cnt_q;
        w_bottom_row = 3'd0;

        case (state_q)
            PLAY: begin
                if (w_hit_valid) begin
                    alive_d[w_hit_index] = 1'b0;
                    score_d              = sat_inc8(score_q);
                    hit_d                = 1'b1;
                end
                if (cnt_q == c_STEP_LAST) begin
                    cnt_d = '0;
                    if (dir_right_q) begin
                        if ({1'b0, fleet_x_q} + c_RIGHT_SPAN == c_X_MAX) begin
                            fleet_y_d   = fleet_y_q + 5'd1;
                            dir_right_d = 1'b0;
                        end else begin
                            fleet_x_d = fleet_x_q + 5'd1;
                        end
                    end else begin
                        if (fleet_x_q == 5'd0) begin
                            fleet_y_d   = fleet_y_q + 5'd1;
                            dir_right_d = 1'b1;
                        end else begin
                            fleet_x_d = fleet_x_q - 5'd1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                wave_d = (alive_d == '0);
            end
            RELOAD: begin
                fleet_x_d   = c_START_X;
                fleet_y_d   = c_START_Y;
                dir_right_d = 1'b1;
                alive_d     = c_ALL_ALIVE;
                cnt_d       = '0;
            end
            default: ;  // OVER: everything frozen
        endcase

        // Lowest live row of the post-update bitmap decides the loss.
        for (int r = 0; r < ROWS; r++) begin
            if (|alive_d[r*COLS +: COLS]) w_bottom_row = 3'(r);
        end
    end

    assign w_empty    = (alive_d == '0);
    assign w_bottom_y = {1'b0, fleet_y_d} + {3'b000, w_bottom_row};
    assign w_lose     = !w_empty && (w_bottom_y >= c_LOSE_ROW);

    // Next-state logic; a cleared wave takes priority over a loss.
    always_comb begin
        state_d = state_q;
        case (state_q)
            PLAY: begin
                if (w_empty)     state_d = RELOAD;
                else if (w_lose) state_d = OVER;
            end
            RELOAD:  state_d = PLAY;
            default: state_d = OVER;
        endcase
    end

    // Outputs; a hit registered on the edge that entered OVER is suppressed.
    always_comb begin
        o_hit        = hit_q && (state_q != OVER);
        o_game_over  = (state_q == OVER);
        o_wave_clear = wave_q;
        o_fleet_x    = fleet_x_q;
        o_fleet_y    = fleet_y_q[3:0];
        o_alive      = alive_q;
        o_score      = score_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_alien_fleet.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alien_fleet
//  Brief    : Scoreboard bench for alien_fleet with a cycle-level fleet model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alien_fleet;

    localparam int ROWS = 4;
    localparam int COLS = 8;
    localparam int STEP = 4;
    localparam int LOSE = 14;

    logic        clk;
    logic        rst;
    logic [4:0]  i_bullet_x;
    logic [3:0]  i_bullet_y;
    logic        o_hit;
    logic [4:0]  o_fleet_x;
    logic [3:0]  o_fleet_y;
    logic [31:0] o_alive;
    logic [7:0]  o_score;
    logic        o_game_over;
    logic        o_wave_clear;

    alien_fleet #(
        .ROWS(ROWS), .COLS(COLS), .STEP_CYCLES(STEP),
        .START_X(0), .START_Y(1), .LOSE_ROW(LOSE)
    ) dut (
        .i_clk_36MHz (clk),
        .i_reset     (rst),
        .i_bullet_x  (i_bullet_x),
        .i_bullet_y  (i_bullet_y),
        .o_hit       (o_hit),
        .o_fleet_x   (o_fleet_x),
        .o_fleet_y   (o_fleet_y),
        .o_alive     (o_alive),
        .o_score     (o_score),
        .o_game_over (o_game_over),
        .o_wave_clear(o_wave_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  x;
        logic [3:0]  y;
        logic [31:0] alive;
        logic [7:0]  score;
        logic        hit;
        logic        wave;
        logic        over;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model state (0=play, 1=reload, 2=over).
    int          m_x, m_y, m_cnt, m_state, m_score;
    bit          m_right, m_hit, m_wave;
    logic [31:0] m_alive;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_x = 0; m_y = 1; m_cnt = 0; m_state = 0; m_score = 0;
        m_right = 1; m_hit = 0; m_wave = 0; m_alive = '1;
    endtask

    task automatic model_edge(input int bx, input int by, output exp_t e);
        bit lose;
        m_hit  = 0;
        m_wave = 0;
        if (m_state == 0) begin
            if (by != 15) begin
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        if (m_alive[r*COLS+c] && bx == m_x + 2*c && by == m_y + r) begin
                            m_alive[r*COLS+c] = 1'b0;
                            m_hit = 1;
                            if (m_score < 255) m_score++;
                        end
            end
            if (m_cnt == STEP - 1) begin
                m_cnt = 0;
                if (m_right) begin
                    if (m_x + 2*COLS - 2 == 31) begin m_y++; m_right = 0; end
                    else m_x++;
                end else begin
                    if (m_x == 0) begin m_y++; m_right = 1; end
                    else m_x--;
                end
            end else begin
                m_cnt++;
            end
            if (m_alive == 0) begin
                m_wave  = 1;
                m_state = 1;
            end else begin
                lose = 0;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        if (m_alive[r*COLS+c] && m_y + r >= LOSE) lose = 1;
                if (lose) m_state = 2;
            end
        end else if (m_state == 1) begin
            m_alive = '1; m_x = 0; m_y = 1; m_right = 1; m_cnt = 0; m_state = 0;
        end
        e.x     = 5'(m_x);
        e.y     = 4'(m_y);
        e.alive = m_alive;
        e.score = 8'(m_score);
        e.hit   = m_hit && (m_state != 2);
        e.wave  = m_wave;
        e.over  = (m_state == 2);
    endtask

    // One clock: drive, predict, let the edge happen, compare at negedge.
    task automatic tick(input int bx, input int by);
        exp_t e;
        i_bullet_x = 5'(bx);
        i_bullet_y = 4'(by);
        model_edge(bx, by, e);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        chk("fleet_x", 32'(o_fleet_x), 32'(e.x));
        chk("fleet_y", 32'(o_fleet_y), 32'(e.y));
        chk("alive", o_alive, e.alive);
        chk("score", 32'(o_score), 32'(e.score));
        chk("hit", 32'(o_hit), 32'(e.hit));
        chk("wave_clear", 32'(o_wave_clear), 32'(e.wave));
        chk("game_over", 32'(o_game_over), 32'(e.over));
    endtask

    task automatic shoot(input int r, input int c);
        tick(m_x + 2*c, m_y + r);
    endtask

    // Reset asserted between edges; outputs must follow immediately.
    task automatic do_reset();
        rst = 1'b1;
        i_bullet_y = 4'd15;
        #1;
        chk("rst_fleet_x", 32'(o_fleet_x), 32'd0);
        chk("rst_fleet_y", 32'(o_fleet_y), 32'd1);
        chk("rst_alive", o_alive, 32'hFFFF_FFFF);
        chk("rst_score", 32'(o_score), 32'd0);
        chk("rst_hit", 32'(o_hit), 32'd0);
        chk("rst_wave", 32'(o_wave_clear), 32'd0);
        chk("rst_over", 32'(o_game_over), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        sb.delete();
    endtask

    initial begin
        rst = 1'b1;
        i_bullet_x = 5'd0;
        i_bullet_y = 4'd15;
        model_reset();
        @(negedge clk);
        do_reset();

        // March right to the edge, drop, then head back left.
        for (int i = 0; i < 72; i++) tick(0, 15);
        chk("edge_x", 32'(o_fleet_x), 32'd17);
        chk("edge_y", 32'(o_fleet_y), 32'd2);
        for (int i = 0; i < 8; i++) tick(0, 15);
        chk("left_x", 32'(o_fleet_x), 32'd15);

        // Mid-game asynchronous reset.
        do_reset();

        // Single hit on alien (1,2) and no re-hit when the bullet stays put.
        tick(4, 2);
        chk("hit_pulse", 32'(o_hit), 32'd1);
        chk("bit10_clear", 32'(o_alive[10]), 32'd0);
        chk("score_one", 32'(o_score), 32'd1);
        tick(4, 2);
        chk("no_rehit", 32'(o_hit), 32'd0);

        // Odd column offset and one cell past the right-most alien.
        tick(3, 1);
        tick(16, 1);
        chk("miss_alive", o_alive, 32'hFFFF_FBFF);

        // Hit on the step terminal cycle uses the pre-step position.
        do_reset();
        for (int i = 0; i < 3; i++) tick(0, 15);
        tick(0, 1);
        chk("tc_bit0", 32'(o_alive[0]), 32'd0);
        chk("tc_moved", 32'(o_fleet_x), 32'd1);

        // Clear the whole wave, then one reload cycle.
        do_reset();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) shoot(r, c);
        chk("wave_pulse", 32'(o_wave_clear), 32'd1);
        tick(0, 15);
        chk("reload_alive", o_alive, 32'hFFFF_FFFF);
        chk("reload_x", 32'(o_fleet_x), 32'd0);
        chk("reload_y", 32'(o_fleet_y), 32'd1);
        chk("wave_score", 32'(o_score), 32'd32);
        for (int i = 0; i < 6; i++) tick(0, 15);

        // Descend with the bottom row alive until the game ends.
        do_reset();
        for (int i = 0; i < 1500 && !o_game_over; i++) tick(0, 15);
        chk("over_reached", 32'(o_game_over), 32'd1);
        chk("over_y", 32'(o_fleet_y), 32'd11);
        for (int i = 0; i < 6; i++) tick(m_x, m_y);
        chk("over_no_hit", 32'(o_hit), 32'd0);

        // Same descent with row 3 destroyed ends one drop later.
        do_reset();
        for (int c = 0; c < COLS; c++) shoot(3, c);
        for (int i = 0; i < 1500 && !o_game_over; i++) tick(0, 15);
        chk("over2_reached", 32'(o_game_over), 32'd1);
        chk("over2_y", 32'(o_fleet_y), 32'd12);
        for (int i = 0; i < 4; i++) tick(0, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
